// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one registered 8-bit ALU among NUM_REQ requesters.
// Optional divide-by-zero trap is enabled by defining ALU_DIV_ZERO_CHECK_EN.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*2-1:0] req_sel,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [1:0]           alu_sel,
    input  logic [7:0]           alu_out,
    input  logic                 alu_carry,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_data,
    output logic                 resp_carry,
    output logic [ID_W-1:0]      resp_id,
    output logic                 resp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic [1:0]      op_sel_q, op_sel_d;
    logic [7:0]      resp_data_q, resp_data_d;
    logic            resp_carry_q, resp_carry_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [7:0]      win_a, win_b;
    logic [1:0]      win_sel;

`ifdef ALU_DIV_ZERO_CHECK_EN
    logic            dz_q, dz_d;
    logic            resp_err_q, resp_err_d;
`endif

    // Two descending passes: the lowest index at/above ptr wins, else the lowest below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i] && (i < int'(ptr_q))) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(ptr_q))) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_idx == ID_W'(i)) begin
                win_a   = req_a[8*i +: 8];
                win_b   = req_b[8*i +: 8];
                win_sel = req_sel[2*i +: 2];
            end
        end
    end

    // No grant is offered while reset is held so nothing can be accepted on a reset edge.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = rst && (state_q == StIdle) && grant_found && (grant_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        resp_data_d  = resp_data_q;
        resp_carry_d = resp_carry_q;
`ifdef ALU_DIV_ZERO_CHECK_EN
        dz_d         = dz_q;
        resp_err_d   = resp_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d  = StIssue;
                    id_d     = grant_idx;
                    ptr_d    = (int'(grant_idx) == int'(NUM_REQ) - 1) ? '0
                                                                      : grant_idx + ID_W'(1);
                    op_a_d   = win_a;
                    op_b_d   = win_b;
                    op_sel_d = win_sel;
`ifdef ALU_DIV_ZERO_CHECK_EN
                    // Feed a harmless divisor so the ALU never sees x/0.
                    dz_d = (win_sel == 2'b11) && (win_b == 8'd0);
                    if (dz_d) begin
                        op_b_d = 8'd1;
                    end
`endif
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                state_d      = StResp;
                resp_data_d  = alu_out;
                resp_carry_d = alu_carry;
`ifdef ALU_DIV_ZERO_CHECK_EN
                resp_err_d = dz_q;
                if (dz_q) begin
                    resp_data_d  = 8'hFF;
                    resp_carry_d = 1'b0;
                end
`endif
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
`ifdef ALU_DIV_ZERO_CHECK_EN
            dz_q         <= 1'b0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            resp_data_q  <= resp_data_d;
            resp_carry_q <= resp_carry_d;
`ifdef ALU_DIV_ZERO_CHECK_EN
            dz_q         <= dz_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_sel    = op_sel_q;
    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;
    assign resp_carry = resp_carry_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != StIdle);

`ifdef ALU_DIV_ZERO_CHECK_EN
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one alu instance (legal 2..8).
REQ-002 Parameter: ID_W, default 2, width of requester index, SHALL equal clog2(NUM_REQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high in any cycle.
REQ-007 req_a, req_b  input  NUM_REQ*8 each  packed operands, requester i at bits [8i+7:8i].
REQ-008 req_sel  input  NUM_REQ*2  packed opcode (00 add, 01 sub, 10 mul, 11 div).
REQ-009 alu_a, alu_b  output  8 each; alu_sel  output  2  operands/opcode to the alu.
REQ-010 alu_out  input  8; alu_carry  input  1  registered alu result and carry (1-cycle latency from alu inputs).
REQ-011 resp_valid  output  1; resp_ready  input  1  result handshake.
REQ-012 resp_data  output  8; resp_carry  output  1; resp_id  output  ID_W; resp_err  output  1.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, ISSUE, CAPTURE, RESP; one transaction in flight at a time.
REQ-015 IDLE: if any req_valid, SHALL assert req_ready (combinationally) only for the round-robin winner; accept on that edge, go ISSUE.
REQ-016 Round-robin: search starts at pointer ptr, ascending with wrap NUM_REQ-1 -> 0; after grant to i, ptr <= (i+1) mod NUM_REQ.
REQ-017 On accept: latch winner's a, b, sel into op registers and winner index into id register.
REQ-018 alu_a/alu_b/alu_sel SHALL be driven from op registers and held stable from ISSUE through RESP.
REQ-019 ISSUE -> CAPTURE unconditionally (alu samples inputs at this edge).
REQ-020 CAPTURE -> RESP unconditionally; on this edge resp_data <= alu_out, resp_carry <= alu_carry.
REQ-021 RESP: resp_valid=1, resp_id = latched index; data/carry/id/err stable until handshake.
REQ-022 RESP & resp_ready -> IDLE; no new accept in the cycle resp completes.
REQ-023 Accept-to-resp_valid latency exactly 2 cycles; minimum 4 cycles per transaction with resp_ready held high.
REQ-024 req_ready SHALL be 0 in ISSUE, CAPTURE, RESP; requests persist until granted.
REQ-025 req_valid dropped before grant: no transaction; ptr unchanged.
REQ-026 resp_carry is alu carry unmodified (carry of A+B regardless of opcode); mul/div results are low 8 bits/quotient as returned.

Reset
REQ-027 On rising edge with rst=0: state IDLE, ptr=0, op/id registers 0, resp_valid=0, resp_data=0, resp_carry=0, resp_id=0, resp_err=0, busy=0, req_ready=0.
REQ-028 Reset mid-transaction SHALL abort it; no response issued for aborted operation.
REQ-029 alu reset is driven by integration, not by this block.

Configuration
REQ-030 Macro ALU_DIV_ZERO_CHECK_EN defined: accepted op with sel=11 and b=0 SHALL drive alu_b=1, follow normal state path, return resp_data=8'hFF, resp_carry=0, resp_err=1.
REQ-031 Macro undefined: no divide-by-zero detection; b forwarded unchanged; resp_err tied 0.

Verification
REQ-032 Reset then all req_valid=0 for 10 cycles -> req_ready=0, resp_valid=0, busy=0 throughout.
REQ-033 Requester 2 only: a=8'd200, b=8'd100, sel=00 -> accept, resp_valid 2 cycles later, resp_data=8'd44, resp_carry=1, resp_id=2.
REQ-034 All four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0 with one grant every 4 cycles.
REQ-035 Requester 1: a=8'd12, b=8'd5, sel=10, resp_ready low 5 cycles -> resp_data=8'd60 held stable, no req_ready until handshake.
REQ-036 With ALU_DIV_ZERO_CHECK_EN: a=8'd9, b=0, sel=11 -> alu_b=1, resp_data=8'hFF, resp_err=1; without macro resp_err stays 0.
REQ-037 rst=0 asserted in CAPTURE -> next cycle IDLE, resp_valid=0, ptr=0; subsequent request served normally.
